// File: rtl/common_enums.sv
// Shared enumerations for the game-play path: screen FSM states, chess-clock
// turn states and the 16-bit seconds arithmetic helpers used by the turn timer.
package common_enums;

    typedef enum logic [1:0] {
        TITLE_SCREEN  = 2'd0,
        SETUP_SCREEN  = 2'd1,
        CHESS_SCREEN  = 2'd2,
        RESULT_SCREEN = 2'd3
    } screen_state_t;

    typedef enum logic [1:0] {
        TT_IDLE  = 2'd0,
        TT_WHITE = 2'd1,
        TT_BLACK = 2'd2,
        TT_OVER  = 2'd3
    } turn_state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic [15:0] sat_dec16(input logic [15:0] a);
        return (a == 16'd0) ? 16'd0 : (a - 16'd1);
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_FREQ_HZ-1 while enabled and pulses tick
// in the cycle the terminal count is reached. Holds its count while disabled.
module sec_tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_FREQ_HZ - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == TERM);

    // Next count: clear wins, then wrap on tick, then advance when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/turn_timer_ctrl.sv
// Chess-clock turn scheduler: alternates white/black, counts each side down and
// flags timeout. Optional per-move increment is built with TURN_TIMER_INCREMENT_EN.
module turn_timer_ctrl
    import common_enums::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
    parameter int unsigned START_SECONDS = 600,
    parameter int unsigned INC_SECONDS   = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  screen_state_t screen_state,
    input  logic          move_done,
    input  logic          pause,
    input  logic          restart,
    output logic          active_black,
    output logic [15:0]   white_secs,
    output logic [15:0]   black_secs,
    output logic          running,
    output logic          turn_start,
    output logic          timeout,
    output logic          loser_black
);

    localparam logic [15:0] START16 = 16'(START_SECONDS);
    localparam logic [15:0] INC16   = 16'(INC_SECONDS);

    turn_state_t state_q, state_d;
    logic        active_black_q, active_black_d;
    logic [15:0] white_secs_q, white_secs_d;
    logic [15:0] black_secs_q, black_secs_d;
    logic        running_q, running_d;
    logic        turn_start_q, turn_start_d;
    logic        timeout_q, timeout_d;
    logic        loser_black_q, loser_black_d;
    logic        clr_s, en_s, tick_s;
    logic [15:0] act_secs_s;

`ifndef TURN_TIMER_INCREMENT_EN
    logic unused_inc_s;
    assign unused_inc_s = ^INC16;
`endif

    assign en_s       = ((state_q == TT_WHITE) || (state_q == TT_BLACK)) && !pause;
    assign act_secs_s = (state_q == TT_BLACK) ? black_secs_q : white_secs_q;

    sec_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en_s),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // Turn sequencing; priority is screen exit > restart > move > tick.
    always_comb begin
        state_d        = state_q;
        active_black_d = active_black_q;
        white_secs_d   = white_secs_q;
        black_secs_d   = black_secs_q;
        timeout_d      = timeout_q;
        loser_black_d  = loser_black_q;
        turn_start_d   = 1'b0;
        clr_s          = 1'b0;
        if (screen_state != CHESS_SCREEN) begin
            state_d        = TT_IDLE;
            active_black_d = 1'b0;
            white_secs_d   = START16;
            black_secs_d   = START16;
            timeout_d      = 1'b0;
            loser_black_d  = 1'b0;
            clr_s          = 1'b1;
        end else begin
            case (state_q)
                TT_IDLE: begin
                    state_d        = TT_WHITE;
                    active_black_d = 1'b0;
                    white_secs_d   = START16;
                    black_secs_d   = START16;
                    turn_start_d   = 1'b1;
                    clr_s          = 1'b1;
                end
                TT_WHITE, TT_BLACK, TT_OVER: begin
                    if (restart) begin
                        state_d        = TT_WHITE;
                        active_black_d = 1'b0;
                        white_secs_d   = START16;
                        black_secs_d   = START16;
                        timeout_d      = 1'b0;
                        loser_black_d  = 1'b0;
                        turn_start_d   = 1'b1;
                        clr_s          = 1'b1;
                    end else if (state_q == TT_OVER) begin
                        state_d = TT_OVER;
                    end else if (move_done && !pause) begin
                        state_d        = (state_q == TT_WHITE) ? TT_BLACK : TT_WHITE;
                        active_black_d = (state_q == TT_WHITE);
                        turn_start_d   = 1'b1;
                        clr_s          = 1'b1;
`ifdef TURN_TIMER_INCREMENT_EN
                        if (state_q == TT_WHITE) begin
                            white_secs_d = sat_add16(white_secs_q, INC16);
                        end else begin
                            black_secs_d = sat_add16(black_secs_q, INC16);
                        end
`endif
                    end else if (tick_s) begin
                        if (state_q == TT_WHITE) begin
                            white_secs_d = sat_dec16(white_secs_q);
                        end else begin
                            black_secs_d = sat_dec16(black_secs_q);
                        end
                        if (act_secs_s == 16'd1) begin
                            state_d       = TT_OVER;
                            timeout_d     = 1'b1;
                            loser_black_d = (state_q == TT_BLACK);
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d        = TT_IDLE;
                    active_black_d = 1'b0;
                    white_secs_d   = START16;
                    black_secs_d   = START16;
                    timeout_d      = 1'b0;
                    loser_black_d  = 1'b0;
                    clr_s          = 1'b1;
                end
            endcase
        end
        running_d = ((state_d == TT_WHITE) || (state_d == TT_BLACK)) && !pause;
    end

    // Turn state and all output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= TT_IDLE;
            active_black_q <= 1'b0;
            white_secs_q   <= START16;
            black_secs_q   <= START16;
            running_q      <= 1'b0;
            turn_start_q   <= 1'b0;
            timeout_q      <= 1'b0;
            loser_black_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            active_black_q <= active_black_d;
            white_secs_q   <= white_secs_d;
            black_secs_q   <= black_secs_d;
            running_q      <= running_d;
            turn_start_q   <= turn_start_d;
            timeout_q      <= timeout_d;
            loser_black_q  <= loser_black_d;
        end
    end

    assign active_black = active_black_q;
    assign white_secs   = white_secs_q;
    assign black_secs   = black_secs_q;
    assign running      = running_q;
    assign turn_start   = turn_start_q;
    assign timeout      = timeout_q;
    assign loser_black  = loser_black_q;

endmodule
